// File: rtl/step_controller_pkg.sv
// Shared constants for the single-step / run controller.
// State encodings are fixed values so existing tools decoding them keep working.
package step_controller_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_HALT = 2'd0;
  localparam state_t ST_STEP = 2'd1;
  localparam state_t ST_RUN  = 2'd2;

  localparam int EN_COUNT_W = 16;

endpackage

// File: rtl/step_controller_debounce_edge.sv
// Push-button conditioner: 2-flop synchronizer, tick-paced debounce, rising-edge press pulse.
// Latency: press is high for one clk, 2 clk sync plus DEBOUNCE_N ticks after a clean press.
// Backpressure: none; a press is a single-cycle pulse and is never held.
module debounce_edge #(
  parameter int DEBOUNCE_N = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic btn,
  output logic press
);

  localparam int CW = 4;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_N - 1);

  logic [1:0]    sync;
  logic          sample;
  logic          sample_prev;
  logic          stable;
  logic          stable_d;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  assign sample = sync[1];

  // cnt_next == CNT_MAX means this sample completes DEBOUNCE_N equal readings in a row
  always_comb begin
    cnt_next = '0;
    if (sample == sample_prev) begin
      cnt_next = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync        <= '0;
      sample_prev <= 1'b0;
      cnt         <= '0;
      stable      <= 1'b0;
      stable_d    <= 1'b0;
    end else begin
      sync     <= {sync[0], btn};
      stable_d <= stable;
      if (tick) begin
        sample_prev <= sample;
        cnt         <= cnt_next;
        if (cnt_next == CNT_MAX && sample != stable) begin
          stable <= sample;
        end
      end
    end
  end

  assign press = stable & ~stable_d;

endmodule

// File: rtl/step_controller.sv
// CPU clock-enable controller: HALT / single STEP / paced RUN driven by two debounced buttons.
// Latency: cpuEn one clk after STEP or after a RUN pacing tick; running/pauseOut lag state by one clk.
// Backpressure: cpuHalt or a mode press forces HALT and cancels a same-cycle pacing request.
module step_controller
  import step_controller_pkg::*;
#(
  parameter int DEBOUNCE_N = 4,
  parameter int RUN_DIV    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic                  btnStep,
  input  logic                  btnMode,
  input  logic                  cpuHalt,
  output logic                  cpuEn,
  output logic                  running,
  output logic                  pauseOut,
  output logic [EN_COUNT_W-1:0] enCount
);

  localparam logic [7:0] DIV_LAST = 8'(RUN_DIV - 1);

  logic                  step_press;
  logic                  mode_press;
  state_t                state;
  state_t                state_next;
  logic [7:0]            div_cnt;
  logic                  run_req;
  logic                  leave_run;
  logic                  en_next;
  logic [EN_COUNT_W-1:0] en_count;

  debounce_edge #(.DEBOUNCE_N(DEBOUNCE_N)) u_step_btn (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .btn   (btnStep),
    .press (step_press)
  );

  debounce_edge #(.DEBOUNCE_N(DEBOUNCE_N)) u_mode_btn (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .btn   (btnMode),
    .press (mode_press)
  );

  // Mode press outranks a simultaneous step press; cpuHalt only blocks entry into RUN
  always_comb begin
    state_next = state;
    case (state)
      ST_HALT: begin
        if (mode_press && !cpuHalt) begin
          state_next = ST_RUN;
        end else if (step_press) begin
          state_next = ST_STEP;
        end
      end
      ST_STEP: state_next = ST_HALT;
      ST_RUN: begin
        if (mode_press || cpuHalt) begin
          state_next = ST_HALT;
        end
      end
      default: state_next = ST_HALT;
    endcase
  end

  assign leave_run = (state == ST_RUN) && (mode_press || cpuHalt);
  assign run_req   = (state == ST_RUN) && tick && (div_cnt == DIV_LAST);
  assign en_next   = !cpuEn && ((state == ST_STEP) || (run_req && !leave_run));

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_HALT;
      div_cnt  <= '0;
      cpuEn    <= 1'b0;
      running  <= 1'b0;
      pauseOut <= 1'b1;
      en_count <= '0;
    end else begin
      state    <= state_next;
      cpuEn    <= en_next;
      running  <= (state == ST_RUN);
      pauseOut <= (state == ST_HALT);
      en_count <= en_count + EN_COUNT_W'(cpuEn);
      if (state != ST_RUN) begin
        div_cnt <= '0;
      end else if (tick) begin
        div_cnt <= (div_cnt == DIV_LAST) ? 8'd0 : div_cnt + 8'd1;
      end
    end
  end

  assign enCount = en_count;

endmodule

// File: tb/tb_step_controller.sv
// Bench for step_controller: scenario table, corner sequences, random traffic vs reference model.
module tb_step_controller;

  localparam int DN = 4;
  localparam int RD = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b0;
  logic        btnStep = 1'b0;
  logic        btnMode = 1'b0;
  logic        cpuHalt = 1'b0;
  logic        cpuEn;
  logic        running;
  logic        pauseOut;
  logic [15:0] enCount;

  step_controller #(.DEBOUNCE_N(DN), .RUN_DIV(RD)) dut (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .btnStep  (btnStep),
    .btnMode  (btnMode),
    .cpuHalt  (cpuHalt),
    .cpuEn    (cpuEn),
    .running  (running),
    .pauseOut (pauseOut),
    .enCount  (enCount)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ph = 1;
  int cyc_no = 0;
  int pulses = 0;
  logic prev_en = 1'b0;
  bit model_on = 0;

  // Reference model: run-length debounce, tick counting in RUN, behavioural mode machine
  typedef enum int {M_HALT, M_STEP, M_RUN} mmode_t;
  mmode_t      m_mode = M_HALT;
  bit          m_sync [2][2];
  bit          m_prev [2];
  bit          m_stable [2];
  bit          m_press [2];
  int          m_run [2];
  int          m_run_ticks = 0;
  bit          m_en = 0;
  bit          m_running = 0;
  bit          m_pause = 1;
  logic [15:0] m_count = '0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc_no);
    end
  endfunction

  task automatic model_step(input bit r, input bit tk, input bit bs, input bit bm, input bit h);
    bit req, leave, en_next, s;
    bit btn [2];
    mmode_t nxt;
    if (r) begin
      m_mode = M_HALT; m_run_ticks = 0;
      m_en = 0; m_running = 0; m_pause = 1; m_count = '0;
      for (int b = 0; b < 2; b++) begin
        m_sync[b][0] = 0; m_sync[b][1] = 0;
        m_prev[b] = 0; m_stable[b] = 0; m_press[b] = 0; m_run[b] = 1;
      end
      return;
    end
    btn[0] = bs;
    btn[1] = bm;
    req     = (m_mode == M_RUN) && tk && ((m_run_ticks + 1) % RD == 0);
    leave   = (m_mode == M_RUN) && (m_press[1] || h);
    en_next = !m_en && ((m_mode == M_STEP) || (req && !leave));
    m_count   = m_count + 16'(m_en);
    m_en      = en_next;
    m_running = (m_mode == M_RUN);
    m_pause   = (m_mode == M_HALT);
    if (m_mode != M_RUN) m_run_ticks = 0;
    else if (tk) m_run_ticks++;
    nxt = m_mode;
    case (m_mode)
      M_HALT:  if (m_press[1] && !h) nxt = M_RUN; else if (m_press[0]) nxt = M_STEP;
      M_STEP:  nxt = M_HALT;
      M_RUN:   if (leave) nxt = M_HALT;
      default: nxt = M_HALT;
    endcase
    m_mode = nxt;
    for (int b = 0; b < 2; b++) begin
      m_press[b] = 0;
      if (tk) begin
        s = m_sync[b][1];
        m_run[b]  = (s == m_prev[b]) ? m_run[b] + 1 : 1;
        m_prev[b] = s;
        if (m_run[b] >= DN && s != m_stable[b]) begin
          m_stable[b] = s;
          m_press[b]  = s;
        end
      end
      m_sync[b][1] = m_sync[b][0];
      m_sync[b][0] = btn[b];
    end
  endtask

  // One clock: model advances on the edge, outputs sampled 1 time unit later
  task automatic cyc();
    bit r, tk, bs, bm, h;
    r = reset; tk = tick; bs = btnStep; bm = btnMode; h = cpuHalt;
    @(posedge clk);
    model_step(r, tk, bs, bm, h);
    #1;
    cyc_no++;
    if (cpuEn === 1'b1) begin
      pulses++;
      chk("en_not_back_to_back", {31'd0, prev_en}, 32'd0);
    end
    prev_en = cpuEn;
    if (model_on)
      chk("model", {13'd0, cpuEn, running, pauseOut, enCount},
                   {13'd0, m_en, m_running, m_pause, m_count});
    ph = (ph + 1) % 8;
    tick = (ph == 0);
  endtask

  task automatic align4();
    while (ph != 4) cyc();
  endtask

  task automatic wait_en(input string name, input int limit);
    int n;
    n = 0;
    while (cpuEn !== 1'b1 && n < limit) begin cyc(); n++; end
    if (cpuEn !== 1'b1) begin
      checks++; errors++;
      $display("FAIL %s: cpuEn not seen within %0d cycles", name, limit);
    end
  endtask

  task automatic wait_running(input string name, input int limit);
    int n;
    n = 0;
    while (running !== 1'b1 && n < limit) begin cyc(); n++; end
    if (running !== 1'b1) begin
      checks++; errors++;
      $display("FAIL %s: running not seen within %0d cycles", name, limit);
    end
  endtask

  typedef struct {
    string name;
    bit    bs, bm, h, tog;
    int    ticks;
    int    pulses;
    bit    run;
    bit    pause;
  } row_t;

  localparam int NROWS = 16;
  row_t rows [NROWS];

  initial begin
    int total;
    int last_pulse;
    rows[0]  = '{"step_press",     1, 0, 0, 0,  6, 1, 0, 1};
    rows[1]  = '{"step_release",   0, 0, 0, 0,  6, 0, 0, 1};
    rows[2]  = '{"bounce",         1, 0, 0, 1, 10, 0, 0, 1};
    rows[3]  = '{"mode_enter_run", 0, 1, 0, 0, 12, 4, 1, 0};
    rows[4]  = '{"mode_release",   0, 0, 0, 0,  4, 2, 1, 0};
    rows[5]  = '{"cpuhalt_stop",   0, 0, 1, 0,  2, 0, 0, 1};
    rows[6]  = '{"step_past_halt", 1, 0, 1, 0,  6, 1, 0, 1};
    rows[7]  = '{"release_all",    0, 0, 0, 0,  6, 0, 0, 1};
    rows[8]  = '{"mode_blocked",   0, 1, 1, 0,  6, 0, 0, 1};
    rows[9]  = '{"release_mode",   0, 0, 0, 0,  6, 0, 0, 1};
    rows[10] = '{"run_again",      0, 1, 0, 0,  6, 1, 1, 0};
    rows[11] = '{"run_free",       0, 0, 0, 0,  6, 3, 1, 0};
    rows[12] = '{"step_in_run",    1, 0, 0, 0,  6, 3, 1, 0};
    rows[13] = '{"step_rel_run",   0, 0, 0, 0,  6, 3, 1, 0};
    rows[14] = '{"mode_to_halt",   0, 1, 0, 0,  6, 2, 0, 1};
    rows[15] = '{"release_halt",   0, 0, 0, 0,  6, 0, 0, 1};

    // Reset state
    reset = 1'b1;
    repeat (3) cyc();
    chk("reset_cpuEn", {31'd0, cpuEn}, 32'd0);
    chk("reset_running", {31'd0, running}, 32'd0);
    chk("reset_pauseOut", {31'd0, pauseOut}, 32'd1);
    chk("reset_enCount", {16'd0, enCount}, 32'd0);
    reset = 1'b0;
    model_on = 1;

    // Scenario table
    total = 0;
    for (int i = 0; i < NROWS; i++) begin
      align4();
      btnStep = rows[i].bs; btnMode = rows[i].bm; cpuHalt = rows[i].h;
      pulses = 0;
      for (int t = 0; t < rows[i].ticks; t++) begin
        if (rows[i].tog && t > 0) btnStep = ~btnStep;
        repeat (8) cyc();
      end
      total += rows[i].pulses;
      chk({rows[i].name, "/pulses"}, pulses, rows[i].pulses);
      chk({rows[i].name, "/running"}, {31'd0, running}, {31'd0, rows[i].run});
      chk({rows[i].name, "/pauseOut"}, {31'd0, pauseOut}, {31'd0, rows[i].pause});
      chk({rows[i].name, "/enCount"}, {16'd0, enCount}, total);
    end
    btnStep = 0; btnMode = 0; cpuHalt = 0;

    // RUN pacing: 5 pulses over 10 ticks, 16 clk apart
    align4();
    btnMode = 1'b1;
    wait_running("pace_enter", 100);
    chk("pace_pauseOut", {31'd0, pauseOut}, 32'd0);
    pulses = 0;
    last_pulse = -1;
    repeat (80) begin
      cyc();
      if (cpuEn === 1'b1) begin
        if (last_pulse >= 0) chk("pace_gap", cyc_no - last_pulse, 32'd16);
        last_pulse = cyc_no;
      end
    end
    chk("pace_pulses", pulses, 32'd5);
    btnMode = 1'b0;

    // cpuHalt on the exact tick of a pacing request: halt wins, no further cpuEn
    wait_en("halt_sync", 40);
    repeat (15) cyc();
    cpuHalt = 1'b1;
    cyc();
    chk("halt_wins_en", {31'd0, cpuEn}, 32'd0);
    cyc();
    chk("halt_running", {31'd0, running}, 32'd0);
    chk("halt_pauseOut", {31'd0, pauseOut}, 32'd1);
    pulses = 0;
    repeat (32) cyc();
    chk("halt_no_en", pulses, 32'd0);
    cpuHalt = 1'b0;
    repeat (40) cyc();

    // Counter wrap from 0xFFFF on a single step
    model_on = 0;
    force dut.en_count = 16'hFFFF;
    repeat (2) cyc();
    release dut.en_count;
    m_count = 16'hFFFF;
    cyc();
    model_on = 1;
    chk("wrap_preload", {16'd0, enCount}, 32'h0000_FFFF);
    align4();
    btnStep = 1'b1;
    pulses = 0;
    repeat (48) cyc();
    btnStep = 1'b0;
    repeat (48) cyc();
    chk("wrap_pulses", pulses, 32'd1);
    chk("wrap_enCount", {16'd0, enCount}, 32'd0);

    // Step and mode pressed on the same tick: RUN, no STEP pulse
    align4();
    btnStep = 1'b1; btnMode = 1'b1;
    pulses = 0;
    repeat (40) cyc();
    chk("simul_no_step", pulses, 32'd0);
    chk("simul_running", {31'd0, running}, 32'd1);
    btnStep = 1'b0; btnMode = 1'b0;
    repeat (48) cyc();

    // Reset on a pacing-request tick mid-RUN: no trailing cpuEn
    wait_en("rst_sync", 40);
    repeat (15) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("rst_run_cpuEn", {31'd0, cpuEn}, 32'd0);
    chk("rst_run_running", {31'd0, running}, 32'd0);
    chk("rst_run_pauseOut", {31'd0, pauseOut}, 32'd1);
    chk("rst_run_enCount", {16'd0, enCount}, 32'd0);
    pulses = 0;
    repeat (32) cyc();
    chk("rst_run_no_en", pulses, 32'd0);

    // Button held through reset release: one press once the level restabilises
    btnStep = 1'b1;
    reset = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;
    pulses = 0;
    repeat (48) cyc();
    chk("held_reset_step", pulses, 32'd1);
    btnStep = 1'b0;
    repeat (48) cyc();

    // Random traffic against the reference model
    for (int i = 0; i < 8000; i++) begin
      if ($urandom_range(0, 39) == 0) btnStep = ~btnStep;
      if ($urandom_range(0, 39) == 0) btnMode = ~btnMode;
      if (cpuHalt == 1'b0) cpuHalt = ($urandom_range(0, 299) == 0);
      else cpuHalt = ($urandom_range(0, 9) != 0);
      reset = ($urandom_range(0, 1999) == 0);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/step_controller.md
STEP_CONTROLLER -- requirements
Module: step_controller

Interface
REQ-001 Parameter DEBOUNCE_N, default 4: consecutive equal tick-sampled button readings required to accept a new level, legal range 2..15.
REQ-002 Parameter RUN_DIV, default 1: in RUN, cpuEn fires once per RUN_DIV ticks, legal range 1..255.
REQ-003 clk  input  1  single system clock; all logic on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 tick  input  1  one-clk pulse from the upstream clock divider; sole time base for debounce and run pacing.
REQ-006 btnStep  input  1  raw, asynchronous single-step push button, active-high.
REQ-007 btnMode  input  1  raw, asynchronous run/halt toggle push button, active-high.
REQ-008 cpuHalt  input  1  level from the CPU requesting a stop, such as a halt instruction.
REQ-009 cpuEn  output  1  one-clk enable pulse that advances the CPU by one cycle.
REQ-010 running  output  1  high while the FSM is in RUN.
REQ-011 pauseOut  output  1  high in HALT; drives the divider pause input.
REQ-012 enCount  output  16  count of cpuEn pulses issued.

Function
REQ-013 Each button passes through a 2-flop synchronizer clocked every clk.
REQ-014 Debounce samples occur only on cycles with tick=1:
- sample equal to previous sample: count increments, saturating at DEBOUNCE_N-1.
- sample differs: count clears to 0.
- count equal to DEBOUNCE_N-1 and sample different from the stable level: stable level takes the sample.
REQ-015 A one-clk press pulse is generated on a 0->1 transition of each debounced stable level; releases generate no pulse.
REQ-016 The FSM has three states: HALT, STEP and RUN.
REQ-017 HALT transitions:
- mode press with cpuHalt=0: go to RUN.
- otherwise, step press: go to STEP.
- mode press wins over a simultaneous step press.
REQ-018 STEP lasts exactly one clk and then returns to HALT unconditionally.
REQ-019 RUN transitions:
- mode press or cpuHalt=1: go to HALT.
- step press: ignored.
REQ-020 Run pacing uses an 8-bit divider counter:
- increments on each tick while in RUN.
- on a tick when it equals RUN_DIV-1, it clears and requests an enable.
- clears whenever the FSM is not in RUN.
REQ-021 cpuEn is registered:
- high for exactly the one clk cycle after the FSM is in STEP.
- high for exactly the one clk cycle after a RUN pacing request.
- never high for two consecutive cycles.
REQ-022 An enable request in the same cycle as a RUN->HALT transition is suppressed; halt wins.
REQ-023 enCount increments by 1 in each cycle cpuEn is high and wraps from 0xFFFF to 0x0000.
REQ-024 running and pauseOut are registered, decoded from the state, and change in the cycle after the state changes.
REQ-025 cpuHalt has no effect on HALT->STEP; single-stepping past a halt is permitted.

Reset
REQ-026 On reset the block sets:
- FSM state: HALT.
- cpuEn=0, running=0, pauseOut=1, enCount=0.
- debounce counters and stable levels: 0; synchronizers: 0.
- run-pacing counter: 0.
REQ-027 Reset asserted mid-RUN or in STEP takes effect at the next clk edge, and no cpuEn pulse follows it.
REQ-028 A button held through reset release yields a press pulse after DEBOUNCE_N ticks, since the stable level restarts at 0.

Structure
REQ-029 State encodings (HALT=2'd0, STEP=2'd1, RUN=2'd2) and the enCount width constant belong in a shared package or include file.
REQ-030 The per-button synchronizer, debounce logic and rising-edge detect form one sub-module, debounce_edge, instantiated twice.

Verification
Bench defaults: DEBOUNCE_N=4, RUN_DIV=2, tick every 8 clk.
REQ-031 Reset: assert reset for 3 clk -> cpuEn=0, running=0, pauseOut=1, enCount=0.
REQ-032 Single step: hold btnStep for 6 ticks in HALT -> exactly one cpuEn pulse and enCount=1; releasing gives no pulse.
REQ-033 Bounce rejection: toggle btnStep on alternate ticks for 10 ticks -> no cpuEn and enCount unchanged.
REQ-034 Run pacing: press btnMode -> running=1 and pauseOut=0; over the next 10 ticks, exactly 5 cpuEn pulses spaced 16 clk apart.
REQ-035 Halt paths and wrap:
- cpuHalt=1 during RUN -> HALT next cycle, no further cpuEn.
- preload enCount=0xFFFF, then one step -> enCount=0x0000.
REQ-036 Simultaneous events and reset mid-run:
- btnStep and btnMode pressed on the same tick in HALT -> RUN entered, no STEP pulse.
- reset mid-RUN -> HALT with no trailing cpuEn.
